// File: rtl/ram_arb_pkg.sv
// Shared types and address-step helpers for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic port_id_t;

    localparam logic [31:0] WORD_STEP = 32'd4;
    localparam logic [31:0] BYTE_STEP = 32'd1;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic bw);
        return addr + (bw ? WORD_STEP : BYTE_STEP);
    endfunction

    function automatic logic [1:0] port_onehot(input port_id_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick: a tie goes to the port that was not granted last.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic       valid,
    output port_id_t   winner
);

    // Choose the winner; a lone requester always wins.
    always_comb begin
        valid  = req[0] | req[1];
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one data RAM between the I-cache refill port (0) and the D-cache port (1),
// sequencing fixed-length bursts and aborting reads that stall for too long.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_bw,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_wready,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_bw,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_wready,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic [31:0] ram_addr,
    inout  wire  [31:0] ram_data,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_oe_n,
    output logic        ram_bw,
    input  logic        ram_hold_i,
    output logic        err_o
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e              state_r;
    port_id_t            owner_r;
    port_id_t            last_grant_r;
    logic                we_r;
    logic                bw_r;
    logic [31:0]         addr_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [1:0]          gnt_r;
    logic [1:0]          wready_r;
    logic [1:0]          rvalid_r;
    logic [1:0]          done_r;
    logic [31:0]         rdata0_r;
    logic [31:0]         rdata1_r;
    logic                ce_n_r;
    logic                we_n_r;
    logic                oe_n_r;
    logic                ram_bw_r;
    logic                drive_r;
    logic                err_r;

    logic                grant_valid_s;
    port_id_t            winner_s;
    logic [31:0]         wdata_s;
    logic                beat_last_s;
    logic                wait_last_s;

    rr_arbiter2 u_rr (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_r),
        .valid      (grant_valid_s),
        .winner     (winner_s)
    );

    assign wdata_s     = (owner_r == 1'b1) ? p1_wdata : p0_wdata;
    assign beat_last_s = (beat_r == BEAT_W'(BURST_LEN - 1));
    assign wait_last_s = (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

    // Burst FSM with all RAM strobes and per-port handshakes registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            we_r         <= 1'b0;
            bw_r         <= 1'b0;
            addr_r       <= 32'd0;
            beat_r       <= BEAT_W'(0);
            wait_cnt_r   <= WAIT_W'(0);
            gnt_r        <= 2'b00;
            wready_r     <= 2'b00;
            rvalid_r     <= 2'b00;
            done_r       <= 2'b00;
            rdata0_r     <= 32'd0;
            rdata1_r     <= 32'd0;
            ce_n_r       <= 1'b1;
            we_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            ram_bw_r     <= 1'b0;
            drive_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            gnt_r    <= 2'b00;
            wready_r <= 2'b00;
            rvalid_r <= 2'b00;
            done_r   <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r    <= winner_s;
                        we_r       <= winner_s ? p1_we : p0_we;
                        bw_r       <= winner_s ? p1_bw : p0_bw;
                        ram_bw_r   <= winner_s ? p1_bw : p0_bw;
                        addr_r     <= winner_s ? p1_addr : p0_addr;
                        beat_r     <= BEAT_W'(0);
                        wait_cnt_r <= WAIT_W'(0);
                        gnt_r      <= port_onehot(winner_s);
                        ce_n_r     <= 1'b0;
                        we_n_r     <= winner_s ? ~p1_we : ~p0_we;
                        oe_n_r     <= winner_s ? p1_we : p0_we;
                        drive_r    <= winner_s ? p1_we : p0_we;
                        wready_r   <= (winner_s ? p1_we : p0_we) ? port_onehot(winner_s) : 2'b00;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (we_r || !ram_hold_i) begin
                        // Beat completes: writes ignore hold, reads capture the bus.
                        if (!we_r) begin
                            if (owner_r == 1'b1) begin
                                rdata1_r <= ram_data;
                            end else begin
                                rdata0_r <= ram_data;
                            end
                            rvalid_r <= port_onehot(owner_r);
                        end else begin
                            rvalid_r <= 2'b00;
                        end
                        addr_r     <= next_addr(addr_r, bw_r);
                        beat_r     <= beat_r + BEAT_W'(1);
                        wait_cnt_r <= WAIT_W'(0);
                        if (beat_last_s) begin
                            state_r <= DONE;
                            ce_n_r  <= 1'b1;
                            we_n_r  <= 1'b1;
                            oe_n_r  <= 1'b1;
                            drive_r <= 1'b0;
                            done_r  <= port_onehot(owner_r);
                        end else begin
                            wready_r <= we_r ? port_onehot(owner_r) : 2'b00;
                        end
                    end else if (wait_last_s) begin
                        err_r   <= 1'b1;
                        state_r <= DONE;
                        ce_n_r  <= 1'b1;
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b1;
                        drive_r <= 1'b0;
                        done_r  <= port_onehot(owner_r);
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                DONE: begin
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ram_data  = drive_r ? wdata_s : 32'hzzzz_zzzz;
    assign ram_addr  = addr_r;
    assign ram_ce_n  = ce_n_r;
    assign ram_we_n  = we_n_r;
    assign ram_oe_n  = oe_n_r;
    assign ram_bw    = ram_bw_r;
    assign err_o     = err_r;
    assign p0_gnt    = gnt_r[0];
    assign p1_gnt    = gnt_r[1];
    assign p0_wready = wready_r[0];
    assign p1_wready = wready_r[1];
    assign p0_rvalid = rvalid_r[0];
    assign p1_rvalid = rvalid_r[1];
    assign p0_done   = done_r[0];
    assign p1_done   = done_r[1];
    assign p0_rdata  = rdata0_r;
    assign p1_rdata  = rdata1_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a scoreboard of expected grants, read words and write beats.
module tb_ram_arbiter;

    localparam int BL = 4;
    localparam int TO = 5;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wexp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p0_bw, p1_req, p1_we, p1_bw;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p0_wready, p0_rvalid, p0_done;
    logic        p1_gnt, p1_wready, p1_rvalid, p1_done;
    logic [31:0] p0_rdata, p1_rdata, ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce_n, ram_we_n, ram_oe_n, ram_bw, ram_hold_i, err_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    logic        gq[$];
    wexp_t       wq[$];
    int          rv_cnt0 = 0, rv_cnt1 = 0, wr_cnt = 0, done_cnt0 = 0, done_cnt1 = 0;
    logic [31:0] wbeat;
    logic        wr_pend;

    function automatic logic [31:0] model(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign p0_wdata = 32'hB0B0_0000 + wbeat;
    assign p1_wdata = 32'hC0DE_0000 + wbeat;
    assign ram_data = (ram_oe_n == 1'b0) ? model(ram_addr) : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    ram_arbiter #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_bw(p0_bw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_wready(p0_wready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_bw(p1_bw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_wready(p1_wready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
        .ram_oe_n(ram_oe_n), .ram_bw(ram_bw), .ram_hold_i(ram_hold_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic port, input logic [31:0] base, input logic bw);
        for (int i = 0; i < BL; i++) begin
            if (port) rq1.push_back(model(base + 32'(i) * (bw ? 32'd4 : 32'd1)));
            else      rq0.push_back(model(base + 32'(i) * (bw ? 32'd4 : 32'd1)));
        end
    endtask

    // Per-cycle scoreboard pops for grants, read beats and write beats.
    task automatic monitor();
        wexp_t e;
        chk("gnt_exclusive", {31'd0, p0_gnt & p1_gnt}, 32'd0);
        if (p0_gnt || p1_gnt) begin
            chk("gnt_expected", {31'd0, gq.size() > 0}, 32'd1);
            if (gq.size() > 0) chk("gnt_port", {31'd0, p1_gnt}, {31'd0, gq.pop_front()});
        end
        if (p0_rvalid) begin
            rv_cnt0++;
            chk("p0_rv_expected", {31'd0, rq0.size() > 0}, 32'd1);
            if (rq0.size() > 0) chk("p0_rdata", p0_rdata, rq0.pop_front());
        end
        if (p1_rvalid) begin
            rv_cnt1++;
            chk("p1_rv_expected", {31'd0, rq1.size() > 0}, 32'd1);
            if (rq1.size() > 0) chk("p1_rdata", p1_rdata, rq1.pop_front());
        end
        if (ram_we_n == 1'b0) begin
            wr_cnt++;
            chk("wr_expected", {31'd0, wq.size() > 0}, 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wr_addr", ram_addr, e.a);
                chk("wr_data", ram_data, e.d);
            end
            chk("wr_wready", {31'd0, p0_wready | p1_wready}, 32'd1);
        end
        if (p0_done) done_cnt0++;
        if (p1_done) done_cnt1++;
        wr_pend = p0_wready | p1_wready;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (wr_pend) wbeat = wbeat + 32'd1;
        wr_pend = 1'b0;
        #1;
        monitor();
    endtask

    task automatic wait_done(input logic port, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            cyc();
            n++;
            seen = port ? p1_done : p0_done;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int n;
        int dsave;
        reset_n = 1'b0; ram_hold_i = 1'b0; wbeat = 32'd0; wr_pend = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_bw = 1'b1; p0_addr = 32'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_bw = 1'b1; p1_addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd7);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_bw_err", {30'd0, ram_bw, err_o}, 32'd0);
        chk("rst_port_flags", {24'd0, p0_gnt, p0_wready, p0_rvalid, p0_done,
                               p1_gnt, p1_wready, p1_rvalid, p1_done}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        reset_n = 1'b1;
        cyc(); cyc();

        // Port 0 word read, no hold.
        p0_we = 1'b0; p0_bw = 1'b1; p0_addr = 32'h1001_0000;
        push_read(1'b0, p0_addr, 1'b1); gq.push_back(1'b0); p0_req = 1'b1;
        cyc();
        chk("t1_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("t1_addr0", ram_addr, 32'h1001_0000);
        chk("t1_strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd2);
        chk("t1_bw", {31'd0, ram_bw}, 32'd1);
        chk("t1_rv_t1", {31'd0, p0_rvalid}, 32'd0);
        p0_req = 1'b0;
        cyc(); chk("t1_addr1", ram_addr, 32'h1001_0004); chk("t1_rv_t2", {31'd0, p0_rvalid}, 32'd1);
        cyc(); chk("t1_addr2", ram_addr, 32'h1001_0008);
        cyc(); chk("t1_addr3", ram_addr, 32'h1001_000C);
        cyc();
        chk("t1_done", {31'd0, p0_done}, 32'd1);
        chk("t1_rv_t5", {31'd0, p0_rvalid}, 32'd1);
        chk("t1_ce_off", {31'd0, ram_ce_n}, 32'd1);
        chk("t1_rv_cnt", 32'(rv_cnt0), 32'd4);
        cyc();
        chk("t1_done_off", {31'd0, p0_done}, 32'd0);

        // Port 1 byte write.
        p1_we = 1'b1; p1_bw = 1'b0; p1_addr = 32'h1001_0010; wbeat = 32'd0; wr_cnt = 0;
        for (int i = 0; i < BL; i++) wq.push_back({32'h1001_0010 + 32'(i), 32'hC0DE_0000 + 32'(i)});
        gq.push_back(1'b1); p1_req = 1'b1;
        cyc();
        chk("t3_gnt", {31'd0, p1_gnt}, 32'd1);
        chk("t3_strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd1);
        chk("t3_bw", {31'd0, ram_bw}, 32'd0);
        p1_req = 1'b0;
        wait_done(1'b1, n);
        chk("t3_done_lat", 32'(n), 32'd4);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("t3_p0_quiet", {30'd0, p0_wready, p0_done}, 32'd0);
        cyc();

        // Port 0 read with three held cycles on beat 0.
        p0_addr = 32'h1001_0040; push_read(1'b0, p0_addr, 1'b1); gq.push_back(1'b0);
        p0_req = 1'b1; ram_hold_i = 1'b1;
        cyc(); p0_req = 1'b0;
        cyc(); cyc();
        chk("t4_addr_held", ram_addr, 32'h1001_0040);
        cyc(); ram_hold_i = 1'b0;
        chk("t4_rv_t4", {31'd0, p0_rvalid}, 32'd0);
        cyc();
        chk("t4_rv_t5", {31'd0, p0_rvalid}, 32'd1);
        wait_done(1'b0, n);
        chk("t4_done_lat", 32'(n), 32'd3);
        chk("t4_err", {31'd0, err_o}, 32'd0);
        cyc();

        // Port 1 read with hold stuck high: watchdog abort.
        p1_we = 1'b0; p1_bw = 1'b1; p1_addr = 32'h1001_0080; gq.push_back(1'b1);
        p1_req = 1'b1; ram_hold_i = 1'b1; dsave = rv_cnt1;
        cyc(); p1_req = 1'b0;
        repeat (4) cyc();
        chk("t5_err_before", {31'd0, err_o}, 32'd0);
        cyc();
        chk("t5_err_set", {31'd0, err_o}, 32'd1);
        chk("t5_done", {31'd0, p1_done}, 32'd1);
        chk("t5_no_rv", 32'(rv_cnt1), 32'(dsave));
        ram_hold_i = 1'b0;
        cyc();
        p0_addr = 32'h1001_00C0; push_read(1'b0, p0_addr, 1'b1); gq.push_back(1'b0); p0_req = 1'b1;
        cyc(); p0_req = 1'b0;
        wait_done(1'b0, n);
        chk("t5_next_lat", 32'(n), 32'd4);
        chk("t5_err_sticky", {31'd0, err_o}, 32'd1);
        cyc();

        // Reset in the middle of beat 2 of a read.
        p0_addr = 32'h1001_0100; push_read(1'b0, p0_addr, 1'b1); gq.push_back(1'b0); p0_req = 1'b1;
        cyc(); p0_req = 1'b0;
        cyc(); cyc();
        reset_n = 1'b0;
        #1;
        chk("t6_strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd7);
        chk("t6_addr", ram_addr, 32'd0);
        chk("t6_err", {31'd0, err_o}, 32'd0);
        chk("t6_rv_rdata", {31'd0, p0_rvalid} | p0_rdata, 32'd0);
        rq0.delete();
        dsave = done_cnt0;
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("t6_no_done", 32'(done_cnt0), 32'(dsave));

        // Both ports request continuously: round-robin from port 0.
        p0_we = 1'b0; p0_bw = 1'b1; p0_addr = 32'h1001_0200;
        p1_we = 1'b0; p1_bw = 1'b1; p1_addr = 32'h1001_0300;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic w;
            w = (k % 2 == 1);
            gq.push_back(w);
            push_read(w, w ? p1_addr : p0_addr, 1'b1);
            wait_done(w, n);
            chk("t2_done_lat", 32'(n), 32'd5);
            if (w) p1_req = 1'b0; else p0_req = 1'b0;
            cyc();
            if (k < 3) begin
                if (w) p1_req = 1'b1; else p0_req = 1'b1;
            end else begin
                p0_req = 1'b0; p1_req = 1'b0;
            end
        end
        repeat (3) cyc();

        chk("end_rq0", 32'(rq0.size()), 32'd0);
        chk("end_rq1", 32'(rq1.size()), 32'd0);
        chk("end_gq", 32'(gq.size()), 32'd0);
        chk("end_wq", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and burst sequencer that shares the single data RAM between the instruction-cache refill path (port 0) and the data-cache path (port 1). It grants one requester at a time with round-robin fairness and drives the RAM's active-low strobes. It steps the address through a fixed-length burst and honours the RAM's `hold_o` wait signal on reads. A watchdog aborts a burst when the RAM stalls too long.

## Interface
- `BURST_LEN`, 4: beats per granted request; power of two, ≥1.
- `TIMEOUT`, 255: maximum consecutive held cycles per read beat before abort; ≥1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pN_req` in 1 (N=0,1): request; sampled only in IDLE.
- `pN_we` in 1: 1 = write burst, 0 = read burst; latched at grant.
- `pN_bw` in 1: 1 = word access, 0 = byte access; latched at grant.
- `pN_addr` in 32: burst base address; latched at grant.
- `pN_wdata` in 32: current write beat; must be valid whenever owner and writing.
- `pN_gnt` out 1: one-cycle pulse in the first ACCESS cycle of this port's burst.
- `pN_wready` out 1: current write beat consumed this cycle; present the next beat next cycle.
- `pN_rvalid` out 1: one-cycle pulse, `pN_rdata` holds a read beat.
- `pN_rdata` out 32: registered read data.
- `pN_done` out 1: one-cycle pulse, burst finished or aborted.
- `ram_addr` out 32: RAM address.
- `ram_data` inout 32: driven only during write ACCESS cycles, else `'z`.
- `ram_ce_n`, `ram_we_n`, `ram_oe_n` out 1: active-low RAM strobes.
- `ram_bw` out 1: word/byte select to RAM.
- `ram_hold_i` in 1: RAM wait; 1 = read data not yet valid.
- `err_o` out 1: sticky timeout flag.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, strobes inactive:
  - One `req` high: grant that port.
  - Both high: grant the port ≠ `last_grant`.
  - On grant, latch owner, `we`, `bw`, `addr`, clear `beat` and `wait_cnt`, then go to ACCESS.
- ACCESS, `ram_ce_n`=0, `ram_addr`=current address, `ram_bw`=latched `bw`:
  - Read: `ram_oe_n`=0, `ram_we_n`=1. A beat completes on an edge with `ram_hold_i`=0. `ram_data` is captured into the owner's `rdata`, and `rvalid` pulses next cycle.
  - Write: `ram_we_n`=0, `ram_oe_n`=1, `ram_data`=owner `wdata`. Each ACCESS cycle completes a beat regardless of `ram_hold_i`. `wready` is high in every write ACCESS cycle.
  - Beat completion: address += 4 if `bw`=1, else += 1; modulo 2^32 wrap; `beat`++, `wait_cnt` cleared. After beat `BURST_LEN-1` completes, go to DONE.
  - Read stall: `wait_cnt`++ per cycle with `ram_hold_i`=1. Reaching `TIMEOUT` sets `err_o` and goes to DONE. No `rvalid` is issued for the remaining beats.
- DONE, strobes inactive:
  - Owner `done` pulses and `last_grant` becomes the owner; go to IDLE next cycle.
  - A requester must drop `req` during `done`; `req` still high in IDLE is a new request.
- Non-owner outputs stay 0 throughout. Requests arriving in ACCESS or DONE wait for IDLE.
- Reset values:
  - State, owner and counters: state IDLE, `last_grant`=1 (port 0 wins the first tie), `beat`=0, `wait_cnt`=0.
  - Port outputs: all `gnt`/`wready`/`rvalid`/`done`/`rdata` 0.
  - RAM side: strobes 1, `ram_addr` 0, `ram_bw` 0, `ram_data` `'z`, `err_o` 0.
- Reset mid-burst: abandon immediately; no `done` is issued. `err_o` is cleared only by reset.

## Timing
- Request at IDLE cycle T leads to ACCESS from T+1 with `gnt` at T+1.
- Read, zero hold, `BURST_LEN`=4:
  - Beats complete at the ends of T+1..T+4.
  - `rvalid` pulses at T+2..T+5, with DONE and `done` at T+5.
  - IDLE at T+6; earliest next grant at T+7.
- Each held cycle on a read delays that beat's completion and all later events by 1.
- Write, `BURST_LEN`=4: `wready` high T+1..T+4, `done` at T+5.
- Back-to-back turnaround: minimum 2 cycles with strobes inactive between bursts (DONE + IDLE).

## Structure
- Package `ram_arb_pkg`: `state_e` {IDLE, ACCESS, DONE}, `port_id_t` (1 bit), `WORD_STEP`=4, `BYTE_STEP`=1.
- Sub-module `rr_arbiter2`: combinational two-request round-robin pick from `req[1:0]` and `last_grant`; outputs `valid` and `winner`.
- Top contains the FSM, address/beat/wait counters, output registers and tristate.

## Test plan
- Port 0 read, base 0x10010000, `BURST_LEN`=4, hold 0 → `ram_addr` 0x10010000/04/08/0C over T+1..T+4. `p0_rvalid` at T+2..T+5 with matching words; `p0_done` at T+5.
- Both ports request simultaneously after reset, repeatedly → grants in order p0, p1, p0, p1; `gnt` never high for both ports.
- Port 1 byte write, `bw`=0, base 0x10010010 → addresses 0x10010010..13; `ram_we_n` low for 4 cycles; `ram_data` `'z` outside them; `p1_wready` for 4 cycles.
- Read with `ram_hold_i` held 3 cycles on beat 0 → beat-0 `rvalid` delayed by 3; `done` at T+8; `err_o` stays 0.
- `TIMEOUT`=5, hold stuck high → `err_o`=1 after 5 held cycles; `done` pulses; no `rvalid`; the next request is still served.
- `reset_n` low during beat 2 of a read → all outputs at reset values asynchronously; no `done`; the first post-reset tie grants p0.
